rename_freelist_mp: RTL and testbench

- Multi-port physical-register free list for the rename stage.
- Each cycle it hands out up to ALLOC_W free physical register tags to rename slots and accepts up to FREE_W released tags from commit.
- It keeps a committed head pointer, so a pipeline flush returns every speculatively allocated tag in one cycle.
- Fully parametrised successor to the single-port rename free-list queue.

---
 rtl/rename_pkg.sv | 51 +++++
 rtl/rename_freelist_mp_ptr.sv | 31 +++
 rtl/rename_freelist_mp.sv | 118 +++++++++++
 tb/tb_rename_freelist_mp.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/rename_pkg.sv
// Shared rename-stage constants and pointer helpers used by the free-list blocks.
package rename_pkg;

    localparam int unsigned PREG_W    = 7;
    localparam int unsigned NUM_PREG  = 128;
    localparam int unsigned ARCH_REGS = 32;

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        while ((64'd1 << r) < 64'(v)) r++;
        return r;
    endfunction

    // Pointer index is sized for the largest possible list so one pointer type serves all users.
    localparam int unsigned PTR_IDX_W = clog2(NUM_PREG);

    typedef logic [PTR_IDX_W:0] ptr_t;

    function automatic ptr_t ptr_add(input ptr_t ptr, input int unsigned n,
                                     input int unsigned depth);
        int unsigned s;
        logic        lap;
        s   = 32'(ptr[PTR_IDX_W-1:0]) + n;
        lap = ptr[PTR_IDX_W];
        if (s >= depth) begin
            s   = s - depth;
            lap = ~lap;
        end
        return {lap, s[PTR_IDX_W-1:0]};
    endfunction

    // Distance from 'from' forward to 'to' in modular depth terms.
    function automatic int unsigned ptr_dist(input ptr_t from, input ptr_t to,
                                             input int unsigned depth);
        if (from[PTR_IDX_W] == to[PTR_IDX_W]) begin
            return 32'(to[PTR_IDX_W-1:0]) - 32'(from[PTR_IDX_W-1:0]);
        end
        return depth - 32'(from[PTR_IDX_W-1:0]) + 32'(to[PTR_IDX_W-1:0]);
    endfunction

    function automatic int unsigned popcount_lo(input logic [31:0] vec, input int unsigned i);
        int unsigned c;
        c = 0;
        for (int unsigned k = 0; k < 32; k++) begin
            if (k < i && vec[k]) c++;
        end
        return c;
    endfunction

endpackage

// File: rtl/rename_freelist_mp_ptr.sv
// Lap/index ring pointer with async reset, modular increment and a load override.
module freelist_ptr_mod
    import rename_pkg::*;
#(
    parameter int unsigned DEPTH   = 96,
    parameter int unsigned N_W     = 2,
    parameter logic        RST_LAP = 1'b0
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [N_W-1:0] inc,
    input  logic           load,
    input  ptr_t           load_ptr,
    output ptr_t           ptr
);

    ptr_t ptr_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= {RST_LAP, PTR_IDX_W'(0)};
        end else if (load) begin
            ptr_q <= load_ptr;
        end else begin
            ptr_q <= ptr_add(ptr_q, 32'(inc), DEPTH);
        end
    end

    assign ptr = ptr_q;

endmodule

// File: rtl/rename_freelist_mp.sv
// Multi-port physical register free list with a committed head for one-cycle flush recovery.
module rename_freelist_mp
    import rename_pkg::*;
#(
    parameter int unsigned PREG_W    = rename_pkg::PREG_W,
    parameter int unsigned NUM_PREG  = rename_pkg::NUM_PREG,
    parameter int unsigned ARCH_REGS = rename_pkg::ARCH_REGS,
    parameter int unsigned ALLOC_W   = 2,
    parameter int unsigned FREE_W    = 2,
    localparam int unsigned DEPTH    = NUM_PREG - ARCH_REGS,
    localparam int unsigned CNT_W    = clog2(DEPTH + 1)
) (
    input  logic                      Clk,
    input  logic                      Rest,
    input  logic [ALLOC_W-1:0]        AllocValid,
    output logic                      AllocReady,
    output logic [ALLOC_W*PREG_W-1:0] AllocPreg,
    input  logic [ALLOC_W-1:0]        CmtValid,
    input  logic [FREE_W-1:0]         FreeValid,
    input  logic [FREE_W*PREG_W-1:0]  FreePreg,
    input  logic                      Flush,
    output logic [CNT_W-1:0]          FreeCount,
    output logic                      Empty,
    output logic                      Overflow
);

    localparam int unsigned MAX_N = (ALLOC_W > FREE_W) ? ALLOC_W : FREE_W;
    localparam int unsigned N_W   = clog2(MAX_N + 1);

    ptr_t              spec_head, cmt_head, tail, spec_load;
    ptr_t              rd_ptr [ALLOC_W];
    ptr_t              wr_ptr [FREE_W];
    logic [N_W-1:0]    alloc_inc, cmt_inc, tail_inc;
    logic [PREG_W-1:0] mem_q [DEPTH];
    int unsigned       n_alloc, n_cmt, n_free, n_accept, free_cnt, uncommitted;
    logic              grant, ovf_q, ovf_d;

    always_comb begin
        n_alloc     = popcount_lo(32'(AllocValid), ALLOC_W);
        n_cmt       = popcount_lo(32'(CmtValid), ALLOC_W);
        n_free      = popcount_lo(32'(FreeValid), FREE_W);
        free_cnt    = ptr_dist(spec_head, tail, DEPTH);
        uncommitted = ptr_dist(cmt_head, spec_head, DEPTH);

        // Releases beyond capacity are dropped and do not move the tail.
        if (free_cnt >= DEPTH)                n_accept = 0;
        else if (free_cnt + n_free > DEPTH)   n_accept = DEPTH - free_cnt;
        else                                  n_accept = n_free;

        AllocReady = (free_cnt >= n_alloc) && !Flush;
        grant      = (AllocValid != '0) && AllocReady;
        alloc_inc  = grant ? N_W'(n_alloc) : '0;
        cmt_inc    = N_W'(n_cmt);
        tail_inc   = N_W'(n_accept);
        spec_load  = ptr_add(cmt_head, n_cmt, DEPTH);

        ovf_d = ovf_q || (free_cnt + n_free > DEPTH) || (n_cmt > uncommitted);

        FreeCount = CNT_W'(free_cnt);
        Empty     = (free_cnt == 0);
        Overflow  = ovf_q;

        AllocPreg = '0;
        for (int i = 0; i < ALLOC_W; i++) begin
            rd_ptr[i] = ptr_add(spec_head, popcount_lo(32'(AllocValid), i), DEPTH);
            AllocPreg[i*PREG_W +: PREG_W] = mem_q[rd_ptr[i][PTR_IDX_W-1:0]];
        end
        for (int j = 0; j < FREE_W; j++) begin
            wr_ptr[j] = ptr_add(tail, popcount_lo(32'(FreeValid), j), DEPTH);
        end
    end

    always_ff @(posedge Clk or negedge Rest) begin
        if (!Rest) begin
            for (int k = 0; k < DEPTH; k++) mem_q[k] <= PREG_W'(ARCH_REGS + k);
        end else begin
            for (int j = 0; j < FREE_W; j++) begin
                if (FreeValid[j] && popcount_lo(32'(FreeValid), j) < n_accept) begin
                    mem_q[wr_ptr[j][PTR_IDX_W-1:0]] <= FreePreg[j*PREG_W +: PREG_W];
                end
            end
        end
    end

    always_ff @(posedge Clk or negedge Rest) begin
        if (!Rest) ovf_q <= 1'b0;
        else       ovf_q <= ovf_d;
    end

    freelist_ptr_mod #(.DEPTH(DEPTH), .N_W(N_W), .RST_LAP(1'b0)) u_spec_head (
        .clk      (Clk),
        .rst_n    (Rest),
        .inc      (alloc_inc),
        .load     (Flush),
        .load_ptr (spec_load),
        .ptr      (spec_head)
    );

    freelist_ptr_mod #(.DEPTH(DEPTH), .N_W(N_W), .RST_LAP(1'b0)) u_cmt_head (
        .clk      (Clk),
        .rst_n    (Rest),
        .inc      (cmt_inc),
        .load     (1'b0),
        .load_ptr ('0),
        .ptr      (cmt_head)
    );

    // Tail starts one lap ahead: the list is full at reset.
    freelist_ptr_mod #(.DEPTH(DEPTH), .N_W(N_W), .RST_LAP(1'b1)) u_tail (
        .clk      (Clk),
        .rst_n    (Rest),
        .inc      (tail_inc),
        .load     (1'b0),
        .load_ptr ('0),
        .ptr      (tail)
    );

endmodule

// File: tb/tb_rename_freelist_mp.sv
// Randomized and directed bench for rename_freelist_mp against a queue-based free-list model.
module tb_rename_freelist_mp;

    localparam int DEPTH = 96;
    localparam int PW    = 7;

    logic        Clk = 1'b0;
    logic        Rest;
    logic [1:0]  AllocValid, CmtValid, FreeValid;
    logic        AllocReady, Flush, Empty, Overflow;
    logic [13:0] AllocPreg, FreePreg;
    logic [6:0]  FreeCount;

    always #5 Clk = ~Clk;

    rename_freelist_mp dut (
        .Clk        (Clk),
        .Rest       (Rest),
        .AllocValid (AllocValid),
        .AllocReady (AllocReady),
        .AllocPreg  (AllocPreg),
        .CmtValid   (CmtValid),
        .FreeValid  (FreeValid),
        .FreePreg   (FreePreg),
        .Flush      (Flush),
        .FreeCount  (FreeCount),
        .Empty      (Empty),
        .Overflow   (Overflow)
    );

    int vectors = 0;
    int miscompares = 0;

    // Model: free tags in hand-out order, allocated-but-uncommitted tags, committed tags.
    int free_q[$];
    int inflight[$];
    int pool[$];
    bit m_ovf;

    task automatic check(input string tag, input int got, input int exp);
        vectors++;
        if (got != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int slot_tag(input int i);
        logic [13:0] v;
        v = AllocPreg;
        return int'(v[i*PW +: PW]);
    endfunction

    task automatic model_reset();
        free_q.delete();
        inflight.delete();
        pool.delete();
        for (int k = 0; k < DEPTH; k++) free_q.push_back(32 + k);
        m_ovf = 1'b0;
    endtask

    task automatic do_reset();
        Rest = 1'b0;
        AllocValid = '0; CmtValid = '0; FreeValid = '0; FreePreg = '0; Flush = 1'b0;
        model_reset();
        @(negedge Clk);
        Rest = 1'b1;
        #1;
    endtask

    task automatic peek(input logic [1:0] av);
        AllocValid = av; CmtValid = '0; FreeValid = '0; Flush = 1'b0;
        #1;
    endtask

    // Drive one cycle, check against the model before the edge, then advance the model.
    task automatic step(input logic [1:0] av, input logic [1:0] cv, input logic [1:0] fv,
                        input int t0, input int t1, input logic fl);
        int n, nc, nf, k, accept;
        bit ready;
        int freed[$];
        n  = int'(av[0]) + int'(av[1]);
        nc = int'(cv[0]) + int'(cv[1]);
        nf = int'(fv[0]) + int'(fv[1]);
        AllocValid = av; CmtValid = cv; FreeValid = fv; Flush = fl;
        FreePreg = {PW'(t1), PW'(t0)};
        #1;
        ready = (free_q.size() >= n) && !fl;
        check("free_count", int'(FreeCount), free_q.size());
        check("empty", int'(Empty), int'(free_q.size() == 0));
        check("alloc_ready", int'(AllocReady), int'(ready));
        check("overflow", int'(Overflow), int'(m_ovf));
        k = 0;
        for (int i = 0; i < 2; i++) begin
            if (av[i] && k < free_q.size()) begin
                check("alloc_preg", slot_tag(i), free_q[k]);
                k++;
            end
        end
        @(posedge Clk);
        if (fv[0]) freed.push_back(t0);
        if (fv[1]) freed.push_back(t1);
        if (free_q.size() + nf > DEPTH || nc > inflight.size()) m_ovf = 1'b1;
        accept = (free_q.size() + nf > DEPTH) ? DEPTH - free_q.size() : nf;
        for (int i = 0; i < nc; i++) if (inflight.size() > 0) pool.push_back(inflight.pop_front());
        if (av != 0 && ready) for (int i = 0; i < n; i++) inflight.push_back(free_q.pop_front());
        if (fl) begin
            for (int i = inflight.size() - 1; i >= 0; i--) free_q.push_front(inflight[i]);
            inflight.delete();
        end
        for (int i = 0; i < accept; i++) free_q.push_back(freed[i]);
        @(negedge Clk);
    endtask

    initial begin
        int guard;
        // Reset state and first allocations.
        do_reset();
        peek(2'b00);
        check("rst_count", int'(FreeCount), 96);
        check("rst_ready", int'(AllocReady), 1);
        check("rst_ovf", int'(Overflow), 0);
        check("rst_empty", int'(Empty), 0);
        peek(2'b11);
        check("rst_slot0", slot_tag(0), 32);
        check("rst_slot1", slot_tag(1), 33);
        step(2'b11, 2'b00, 2'b00, 0, 0, 1'b0);
        peek(2'b01);
        check("a2_count", int'(FreeCount), 94);
        check("a2_slot0", slot_tag(0), 34);
        peek(2'b10);
        check("packed_slot1", slot_tag(1), 34);
        step(2'b10, 2'b00, 2'b00, 0, 0, 1'b0);

        // Drain to one, then an oversized request must stall.
        guard = 0;
        while (free_q.size() > 1 && guard < 100) begin
            step(2'b11, 2'b00, 2'b00, 0, 0, 1'b0);
            guard++;
        end
        peek(2'b11);
        check("stall_ready", int'(AllocReady), 0);
        check("stall_count", int'(FreeCount), 1);
        step(2'b11, 2'b00, 2'b00, 0, 0, 1'b0);
        peek(2'b00);
        check("stall_hold", int'(FreeCount), 1);
        step(2'b01, 2'b00, 2'b00, 0, 0, 1'b0);
        peek(2'b00);
        check("drain_empty", int'(Empty), 1);

        // Flush after separate commit.
        do_reset();
        step(2'b11, 2'b00, 2'b00, 0, 0, 1'b0);
        step(2'b11, 2'b00, 2'b00, 0, 0, 1'b0);
        step(2'b01, 2'b00, 2'b00, 0, 0, 1'b0);
        step(2'b00, 2'b11, 2'b00, 0, 0, 1'b0);
        step(2'b00, 2'b00, 2'b00, 0, 0, 1'b1);
        peek(2'b01);
        check("flush_count", int'(FreeCount), 94);
        check("flush_slot0", slot_tag(0), 34);

        // Flush in the same cycle as a commit.
        do_reset();
        step(2'b11, 2'b00, 2'b00, 0, 0, 1'b0);
        step(2'b11, 2'b00, 2'b00, 0, 0, 1'b0);
        step(2'b01, 2'b00, 2'b00, 0, 0, 1'b0);
        step(2'b00, 2'b11, 2'b00, 0, 0, 1'b0);
        step(2'b01, 2'b01, 2'b00, 0, 0, 1'b1);
        peek(2'b01);
        check("flushc_count", int'(FreeCount), 93);
        check("flushc_slot0", slot_tag(0), 35);

        // Wrap-around: allocate everything, then refill two entries.
        do_reset();
        for (int i = 0; i < DEPTH / 2; i++) step(2'b11, 2'b00, 2'b00, 0, 0, 1'b0);
        step(2'b00, 2'b00, 2'b11, 10, 11, 1'b0);
        peek(2'b11);
        check("wrap_count", int'(FreeCount), 2);
        check("wrap_slot0", slot_tag(0), 10);
        check("wrap_slot1", slot_tag(1), 11);

        // Overflow on a release into a full list; sticky until async reset.
        do_reset();
        step(2'b00, 2'b00, 2'b01, 5, 0, 1'b0);
        peek(2'b11);
        check("ovf_set", int'(Overflow), 1);
        check("ovf_count", int'(FreeCount), 96);
        check("ovf_dropped", slot_tag(0), 32);
        step(2'b00, 2'b00, 2'b00, 0, 0, 1'b0);
        step(2'b00, 2'b00, 2'b00, 0, 0, 1'b0);
        peek(2'b00);
        check("ovf_sticky", int'(Overflow), 1);
        #1;
        Rest = 1'b0;
        #1;
        check("async_ovf", int'(Overflow), 0);
        check("async_count", int'(FreeCount), 96);
        model_reset();
        @(negedge Clk);
        Rest = 1'b1;
        #1;

        // Randomized traffic with legal commits and frees.
        for (int c = 0; c < 600; c++) begin
            logic [1:0] av, cv, fv;
            int nc, nf, t0, t1, idx;
            logic fl;
            av = 2'($urandom_range(0, 3));
            fl = ($urandom_range(0, 15) == 0);
            nc = $urandom_range(0, (inflight.size() < 2) ? inflight.size() : 2);
            cv = (nc == 2) ? 2'b11 : (nc == 1) ? ($urandom_range(0, 1) ? 2'b01 : 2'b10) : 2'b00;
            nf = $urandom_range(0, (pool.size() < 2) ? pool.size() : 2);
            t0 = $urandom_range(0, 127);
            t1 = $urandom_range(0, 127);
            fv = 2'b00;
            if (nf >= 1) begin
                idx = $urandom_range(0, pool.size() - 1);
                t0 = pool[idx];
                pool.delete(idx);
                fv = 2'b01;
            end
            if (nf == 2) begin
                idx = $urandom_range(0, pool.size() - 1);
                t1 = pool[idx];
                pool.delete(idx);
                fv = 2'b11;
            end else if (nf == 1 && $urandom_range(0, 1) == 1) begin
                t1 = t0;
                fv = 2'b10;
            end
            step(av, cv, fv, t0, t1, fl);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
